// File: rtl/pwm_duty_ctrl_if.sv
// rtl/pwm_duty_ctrl_if.sv - user-facing signal bundle for the PWM duty controller
//
// Purpose: groups the switch/button/display/PWM signals of pwm_duty_ctrl.
// Ports (signals):
//   en       global enable switch level
//   up/down  raw button levels (asynchronous)
//   ch_sel   channel addressed by the buttons and shown on the display
//   pwm_out  one PWM waveform per channel
//   HEX0..2  units/tens/hundreds digit of the selected duty, active-low segments
// Modports: master drives the controls and observes outputs; slave is the controller.
interface pwm_duty_ctrl_if #(
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                en;
    logic                up;
    logic                down;
    logic [CH_W-1:0]     ch_sel;
    logic [CHANNELS-1:0] pwm_out;
    logic [6:0]          HEX0;
    logic [6:0]          HEX1;
    logic [6:0]          HEX2;

    modport master (
        output en, up, down, ch_sel,
        input  pwm_out, HEX0, HEX1, HEX2
    );

    modport slave (
        input  en, up, down, ch_sel,
        output pwm_out, HEX0, HEX1, HEX2
    );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// rtl/pwm_duty_ctrl.sv - multi-channel PWM with button-stepped duty and 7-segment readout
//
// Purpose: each channel holds a duty 0..100 %, stepped by STEP with up/down buttons
// on the channel chosen by ch_sel. A shared 0..99 period counter (advanced every
// PRESCALE clocks) compares against per-channel shadow duties that only reload at
// the period wrap, so edits never glitch a running period.
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    pwm_duty_ctrl_if.slave (en, up, down, ch_sel, pwm_out, HEX0..HEX2)
module pwm_duty_ctrl #(
    parameter int CHANNELS = 4,
    parameter int STEP     = 10,
    parameter int PRESCALE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_duty_ctrl_if.slave bus
);

    localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [6:0]      STEP7    = 7'(STEP);
    localparam logic [6:0]      MAX_DUTY = 7'd100;
    localparam logic [6:0]      CNT_LAST = 7'd99;

    // Button synchronisers and rising-edge detectors.
    logic up_s1, up_s2, up_d, up_armed;
    logic dn_s1, dn_s2, dn_d, dn_armed;
    // Goes high one cycle after reset release, so the cleared sync chain is not
    // mistaken for a released button.
    logic sync_live;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_s1     <= 1'b0;
            up_s2     <= 1'b0;
            up_d      <= 1'b0;
            up_armed  <= 1'b0;
            dn_s1     <= 1'b0;
            dn_s2     <= 1'b0;
            dn_d      <= 1'b0;
            dn_armed  <= 1'b0;
            sync_live <= 1'b0;
        end else begin
            up_s1     <= bus.up;
            up_s2     <= up_s1;
            up_d      <= up_s2;
            dn_s1     <= bus.down;
            dn_s2     <= dn_s1;
            dn_d      <= dn_s2;
            sync_live <= 1'b1;
            // A button only arms once it has been seen released after reset,
            // so a press held through reset release never counts.
            up_armed  <= up_armed | (sync_live & ~up_s1 & ~up_s2);
            dn_armed  <= dn_armed | (sync_live & ~dn_s1 & ~dn_s2);
        end
    end

    logic up_pulse, dn_pulse, step_up, step_dn;
    assign up_pulse = up_s2 & ~up_d & up_armed;
    assign dn_pulse = dn_s2 & ~dn_d & dn_armed;
    // Coincident up and down cancel; nothing applies while disabled.
    assign step_up  = bus.en & up_pulse & ~dn_pulse;
    assign step_dn  = bus.en & dn_pulse & ~up_pulse;

    logic [6:0] duty   [CHANNELS];
    logic [6:0] shadow [CHANNELS];
    logic [6:0] sel_duty;
    logic [6:0] up_val, dn_val;

    // Out-of-range ch_sel (non power-of-two CHANNELS) reads as 0 and edits nothing.
    always_comb begin
        sel_duty = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(bus.ch_sel) == i) begin
                sel_duty = duty[i];
            end
        end
    end

    // Saturating step, compared before adding so the 7-bit sum never exceeds 100.
    assign up_val = (sel_duty > (MAX_DUTY - STEP7)) ? MAX_DUTY : (sel_duty + STEP7);
    assign dn_val = (sel_duty < STEP7) ? 7'd0 : (sel_duty - STEP7);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(bus.ch_sel) == i) begin
                    if (step_up) begin
                        duty[i] <= up_val;
                    end else if (step_dn) begin
                        duty[i] <= dn_val;
                    end
                end
            end
        end
    end

    // Prescaler, period counter and shadow duties.
    logic [PS_W-1:0] presc;
    logic [6:0]      cnt;
    logic            tick, wrap;

    assign tick = (presc == PS_LAST);
    assign wrap = tick && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            cnt   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else if (!bus.en) begin
            // Parked at the start of a period, tracking live duties, so
            // enabling begins a clean period.
            presc <= '0;
            cnt   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= duty[i];
            end
        end else begin
            presc <= tick ? '0 : (presc + PS_W'(1));
            if (tick) begin
                cnt <= wrap ? 7'd0 : (cnt + 7'd1);
            end
            if (wrap) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    shadow[i] <= duty[i];
                end
            end
        end
    end

    logic [CHANNELS-1:0] pwm;
    always_comb begin
        pwm = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm[i] = bus.en && (cnt < shadow[i]);
        end
    end
    assign bus.pwm_out = pwm;

    // Decimal display of the selected duty.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic       hund;
    logic [6:0] rem;
    logic [3:0] tens, units;

    // Duty never exceeds 100, so the hundreds digit is a single comparison.
    assign hund  = (sel_duty >= MAX_DUTY);
    assign rem   = hund ? (sel_duty - MAX_DUTY) : sel_duty;
    assign tens  = 4'(rem / 7'd10);
    assign units = 4'(rem % 7'd10);

    assign bus.HEX2 = bus.en ? seg7({3'b000, hund}) : 7'b1111111;
    assign bus.HEX1 = bus.en ? seg7(tens)           : 7'b1111111;
    assign bus.HEX0 = bus.en ? seg7(units)          : 7'b1111111;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb/tb_pwm_duty_ctrl.sv - directed scoreboard bench for pwm_duty_ctrl
module tb_pwm_duty_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_duty_ctrl_if #(.CHANNELS(4), .CH_W(2)) bus ();

    pwm_duty_ctrl #(.CHANNELS(4), .STEP(10), .PRESCALE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    string       tag_q[$];
    logic [31:0] val_q[$];
    int total = 0;
    int bad   = 0;
    int hi0, hi2;
    int dm[4];

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:       seg = 7'b1000000;
            1:       seg = 7'b1111001;
            2:       seg = 7'b0100100;
            3:       seg = 7'b0110000;
            4:       seg = 7'b0011001;
            5:       seg = 7'b0010010;
            6:       seg = 7'b0000010;
            7:       seg = 7'b1111000;
            8:       seg = 7'b0000000;
            9:       seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [31:0] hex_of(input int d);
        hex_of = {11'd0, seg(d / 100), seg((d / 10) % 10), seg(d % 10)};
    endfunction

    function automatic logic [31:0] disp();
        disp = {11'd0, bus.HEX2, bus.HEX1, bus.HEX0};
    endfunction

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        val_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] v;
        total++;
        if (val_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            v = val_q.pop_front();
            assert (obs === v) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.pwm_out[0] === 1'b1) hi0++;
        if (bus.pwm_out[2] === 1'b1) hi2++;
    endtask

    task automatic press(input bit is_up, input int ch);
        bus.ch_sel = 2'(ch);
        if (is_up) bus.up = 1'b1; else bus.down = 1'b1;
        repeat (3) tick();
        bus.up   = 1'b0;
        bus.down = 1'b0;
        repeat (3) tick();
        if (bus.en) begin
            if (is_up) dm[ch] = (dm[ch] + 10 > 100) ? 100 : dm[ch] + 10;
            else       dm[ch] = (dm[ch] < 10) ? 0 : dm[ch] - 10;
        end
    endtask

    task automatic check_ch(input int ch);
        bus.ch_sel = 2'(ch);
        #1;
        push($sformatf("disp_ch%0d", ch), hex_of(dm[ch]));
        check(disp());
    endtask

    initial begin
        bus.en = 1'b1; bus.up = 1'b0; bus.down = 1'b0; bus.ch_sel = 2'd0;
        for (int i = 0; i < 4; i++) dm[i] = 0;
        hi0 = 0; hi2 = 0;

        rst_n = 1'b0;
        repeat (3) tick();
        push("pwm_during_reset", 32'd0); check({28'd0, bus.pwm_out});
        rst_n = 1'b1;
        tick();
        push("hex2_reset", 32'b1000000); check({25'd0, bus.HEX2});
        push("hex1_reset", 32'b1000000); check({25'd0, bus.HEX1});
        push("hex0_reset", 32'b1000000); check({25'd0, bus.HEX0});
        push("pwm_after_reset", 32'd0);  check({28'd0, bus.pwm_out});

        // One long press counts once.
        bus.ch_sel = 2'd1; bus.up = 1'b1;
        repeat (20) tick();
        bus.up = 1'b0;
        repeat (3) tick();
        dm[1] = 10;
        push("hold20_hex1", 32'b1111001); check({25'd0, bus.HEX1});
        push("hold20_hex0", 32'b1000000); check({25'd0, bus.HEX0});
        check_ch(0); check_ch(2); check_ch(3);

        // Input rises before edge k: unchanged after k+1, updated at k+2.
        bus.ch_sel = 2'd1; bus.up = 1'b1;
        tick(); tick();
        push("latency_k1", hex_of(10)); check(disp());
        tick();
        dm[1] = 20;
        push("latency_k2", hex_of(20)); check(disp());
        bus.up = 1'b0;
        repeat (3) tick();

        // Saturation at 100 and constant-high output.
        for (int i = 0; i < 11; i++) press(1'b1, 2);
        check_ch(2);
        repeat (100) tick();
        hi2 = 0;
        repeat (100) tick();
        push("pwm2_full_period", 32'd100); check(hi2);

        // Down at zero stays zero.
        press(1'b0, 3);
        check_ch(3);

        // Coincident up/down at 40.
        for (int i = 0; i < 6; i++) press(1'b0, 2);
        check_ch(2);
        bus.ch_sel = 2'd2; bus.up = 1'b1; bus.down = 1'b1;
        repeat (3) tick();
        bus.up = 1'b0; bus.down = 1'b0;
        repeat (3) tick();
        check_ch(2);

        // Disabled: blank display, no output, presses discarded.
        bus.en = 1'b0;
        #1;
        push("hex_blank", 32'h1FFFFF); check(disp());
        push("pwm_disabled", 32'd0);   check({28'd0, bus.pwm_out});
        press(1'b1, 2);
        bus.en = 1'b1;
        check_ch(2);

        // Period timing on ch0: 30, then a mid-period edit to 50.
        for (int i = 0; i < 3; i++) press(1'b1, 0);
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        #1;
        hi0 = (bus.pwm_out[0] === 1'b1) ? 1 : 0;
        press(1'b1, 0);
        press(1'b1, 0);
        repeat (87) tick();
        push("period_duty30", 32'd30); check(hi0);
        hi0 = 0;
        repeat (100) tick();
        push("period_duty50", 32'd50); check(hi0);

        // Reset while ch3 at 70 and high.
        for (int i = 0; i < 7; i++) press(1'b1, 3);
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        repeat (5) tick();
        push("pwm3_high", 32'd1); check({31'd0, bus.pwm_out[3]});
        rst_n = 1'b0;
        tick();
        push("pwm_after_midreset", 32'd0); check({28'd0, bus.pwm_out});

        // Button held through reset release must not step.
        bus.ch_sel = 2'd0; bus.up = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        bus.up = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) dm[i] = 0;
        for (int i = 0; i < 4; i++) check_ch(i);
        press(1'b1, 0);
        check_ch(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
